exec_ctrl: RTL and testbench
============================

Name: exec_ctrl

Overview:
Execution controller that sequences the processor core through a single-cycle clock-enable (cpu_en) instead of a gated or muxed clock.
- Modes: free-running auto mode at a programmable period, single-step mode, and halt on a PC breakpoint.
- Sits between the board-level debounce/pulse conditioning and the processor.
- Replaces the combinational clock select between the divided clock and the step button.

Parameters:
DIV_W, 26, width of auto-mode period divisor and internal divide counter
ADDR_W, 8, width of program counter / breakpoint address
CNT_W, 16, width of executed-cycle counter

Ports:
clk  in  1  system clock; the whole block and the processor's enable domain run on it
rst  in  1  reset, synchronous, active-high
mode  in  1  0 = AUTO, 1 = STEP (already debounced)
divisor  in  DIV_W  auto-mode period minus 1, in clk cycles
run  in  1  one-cycle pulse: resume auto execution
halt  in  1  one-cycle pulse: stop execution
step  in  1  one-cycle pulse: execute exactly one processor cycle
pc  in  ADDR_W  current processor memory address
brk_addr  in  ADDR_W  breakpoint address
brk_en  in  1  breakpoint enable
cpu_en  out  1  one-cycle processor clock-enable
state  out  2  00 HALT, 01 RUN, 10 BRK, 11 STEP
cycles  out  CNT_W  count of cpu_en pulses issued
tick  out  1  toggles on every cpu_en (heartbeat LED)

Behaviour:
- Reset (sync, active-high, highest priority) values:
  - state = HALT; cpu_en = 0; cycles = 0; tick = 0.
  - Divide counter = 0; skip_brk flag = 0.
  - Reset asserted mid-run clears everything on the next edge.
- All outputs are registered.
- Command priority in a single cycle: halt > step > run.
- HALT / BRK states:
  - step → STEP for exactly one cycle, with cpu_en = 1 in that cycle (latency 1: step at edge n gives cpu_en high during cycle n+1).
  - After STEP, return to HALT.
  - run, when mode = 0 → RUN, divide counter = 0.
  - run, when mode = 1 → ignored.
- STEP state: always lasts one cycle. Commands arriving during STEP are dropped.
- RUN state:
  - Divide counter increments every cycle.
  - When counter >= divisor: cpu_en = 1 for one cycle and counter reloads to 0.
  - divisor = 0 gives cpu_en every cycle.
  - A divisor lowered below the current count issues on the next cycle (>= compare).
  - halt → HALT next cycle; no further cpu_en; counter cleared.
  - mode = 1 while in RUN → HALT (same as halt).
  - step in RUN → ignored.
- Breakpoint:
  - Condition: in RUN, when an issue is due and brk_en = 1 and pc == brk_addr.
  - Result: the issue is suppressed, state → BRK, counter cleared.
  - Leaving BRK via run or step sets skip_brk.
  - The first issue after that bypasses the compare, so the same address is not re-hit immediately; skip_brk clears on that issue.
- cycles increments on every cpu_en and wraps modulo 2^CNT_W.
- tick toggles on every cpu_en.

Optional Feature:
EXEC_CTRL_BRK_EN
- Defined: breakpoint compare, BRK state and skip_brk logic are present as described.
- Undefined:
  - brk_addr, brk_en and pc are ignored; state never reports 10.
  - RUN exits only via halt, mode = 1, or rst.

Test Plan:
- rst = 1 for 2 cycles → state = 00, cpu_en = 0, cycles = 0, tick = 0.
- Single-step: mode = 1, step pulse at cycle 10 → cpu_en high only in cycle 11, state = 11 in cycle 11, then 00; cycles = 1, tick = 1.
- Auto run: mode = 0, divisor = 3, run pulse → cpu_en every 4th cycle; after 5 issues cycles = 5; halt pulse → no cpu_en afterwards, state = 00.
- Priority: halt+step+run in the same cycle from RUN → HALT, no cpu_en; step+run together from HALT → one STEP issue, then HALT.
- Breakpoint (macro defined): divisor = 0, brk_en = 1, brk_addr = 8'h05, pc ramps 0,1,2,… per issue → 5 issues then state = 10; run → execution resumes at pc = 5 without re-halting.
- Breakpoint (macro undefined), same stimulus → no stop at 8'h05.
- Wrap: CNT_W = 4, divisor = 0, run for 17 issues → cycles = 1.

Source files
------------

// File: rtl/exec_ctrl.sv
// exec_ctrl: execution controller that sequences the processor through a
// single-cycle clock-enable (cpu_en). It supports free-running auto mode at
// a programmable period, single-step mode and an optional PC breakpoint.
// Optional feature macro: EXEC_CTRL_BRK_EN (breakpoint compare, BRK state
// and skip_brk logic). When it is undefined, pc/brk_addr/brk_en are ignored.
module exec_ctrl #(
    parameter int DIV_W  = 26,
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mode,
    input  logic [DIV_W-1:0]  divisor,
    input  logic              run,
    input  logic              halt,
    input  logic              step,
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] brk_addr,
    input  logic              brk_en,
    output logic              cpu_en,
    output logic [1:0]        state,
    output logic [CNT_W-1:0]  cycles,
    output logic              tick
);

    typedef enum logic [1:0] {
        ST_HALT = 2'b00,
        ST_RUN  = 2'b01,
        ST_BRK  = 2'b10,
        ST_STEP = 2'b11
    } state_t;

    state_t           state_r;
    state_t           state_nxt;
    logic [DIV_W-1:0] div_cnt_r;
    logic [DIV_W-1:0] div_cnt_nxt;
    logic             skip_brk_r;
    logic             skip_brk_nxt;
    logic             cpu_en_nxt;
    logic             brk_hit_s;

`ifdef EXEC_CTRL_BRK_EN
    // Breakpoint hit: address match, unless this is the first issue after leaving BRK.
    always_comb begin
        brk_hit_s = brk_en && (pc == brk_addr) && !skip_brk_r;
    end
`else
    // Breakpoint hardware absent: the address inputs are intentionally unused.
    logic unused_brk_s;
    assign unused_brk_s = ^{pc, brk_addr, brk_en};
    assign brk_hit_s    = 1'b0;
`endif

    // Next-state, next-enable and divide-counter decode; halt > step > run.
    always_comb begin
        state_nxt    = state_r;
        cpu_en_nxt   = 1'b0;
        div_cnt_nxt  = div_cnt_r;
        skip_brk_nxt = skip_brk_r;
        case (state_r)
            ST_HALT, ST_BRK: begin
                if (halt) begin
                    state_nxt = ST_HALT;
                end else if (step) begin
                    state_nxt  = ST_STEP;
                    cpu_en_nxt = 1'b1;
                    if (state_r == ST_BRK) begin
                        skip_brk_nxt = 1'b1;
                    end else begin
                        skip_brk_nxt = skip_brk_r;
                    end
                end else if (run && !mode) begin
                    state_nxt   = ST_RUN;
                    div_cnt_nxt = {DIV_W{1'b0}};
                    if (state_r == ST_BRK) begin
                        skip_brk_nxt = 1'b1;
                    end else begin
                        skip_brk_nxt = skip_brk_r;
                    end
                end else begin
                    state_nxt = state_r;
                end
            end
            ST_RUN: begin
                if (halt || mode) begin
                    state_nxt   = ST_HALT;
                    div_cnt_nxt = {DIV_W{1'b0}};
                end else if (div_cnt_r >= divisor) begin
                    // Issue is due; a lowered divisor fires on the next cycle.
                    div_cnt_nxt = {DIV_W{1'b0}};
                    if (brk_hit_s) begin
                        state_nxt = ST_BRK;
                    end else begin
                        cpu_en_nxt   = 1'b1;
                        skip_brk_nxt = 1'b0;
                    end
                end else begin
                    div_cnt_nxt = div_cnt_r + DIV_W'(1);
                end
            end
            ST_STEP: begin
                // Single issue already made on entry; commands here are dropped.
                state_nxt = ST_HALT;
            end
            default: begin
                state_nxt   = ST_HALT;
                div_cnt_nxt = {DIV_W{1'b0}};
            end
        endcase
    end

    // State, divider, enable, counter and heartbeat registers with sync reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_HALT;
            div_cnt_r  <= {DIV_W{1'b0}};
            skip_brk_r <= 1'b0;
            cpu_en     <= 1'b0;
            cycles     <= {CNT_W{1'b0}};
            tick       <= 1'b0;
        end else begin
            state_r    <= state_nxt;
            div_cnt_r  <= div_cnt_nxt;
            skip_brk_r <= skip_brk_nxt;
            cpu_en     <= cpu_en_nxt;
            if (cpu_en_nxt) begin
                cycles <= cycles + CNT_W'(1);
                tick   <= ~tick;
            end else begin
                cycles <= cycles;
                tick   <= tick;
            end
        end
    end

    assign state = state_r;

endmodule

// File: tb/tb_exec_ctrl.sv
// Directed testbench for exec_ctrl; CNT_W is reduced to 4 so the cycle
// counter wrap can be reached quickly. Inputs change and outputs are
// sampled on the falling clock edge.
module tb_exec_ctrl;

    logic        clk;
    logic        rst;
    logic        mode;
    logic [25:0] divisor;
    logic        run;
    logic        halt;
    logic        step;
    logic [7:0]  pc;
    logic [7:0]  brk_addr;
    logic        brk_en;
    logic        cpu_en;
    logic [1:0]  state;
    logic [3:0]  cycles;
    logic        tick;

    int vectors;
    int miscompares;

    exec_ctrl #(.DIV_W(26), .ADDR_W(8), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .mode(mode), .divisor(divisor),
        .run(run), .halt(halt), .step(step), .pc(pc),
        .brk_addr(brk_addr), .brk_en(brk_en), .cpu_en(cpu_en),
        .state(state), .cycles(cycles), .tick(tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Processor model: pc advances during each enabled cycle.
    always @(negedge clk) begin
        if (rst) pc = 8'd0;
        else if (cpu_en) pc = pc + 8'd1;
    end

    task automatic do_reset();
        rst = 1'b1; run = 1'b0; halt = 1'b0; step = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic pulse_run();
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
    endtask

    task automatic test_reset();
        mode = 1'b1; divisor = 26'd0; brk_addr = 8'd0; brk_en = 1'b0;
        do_reset();
        vectors++; if (state !== 2'b00) begin miscompares++; $display("FAIL reset_state got %b want 00", state); end
        vectors++; if (cpu_en !== 1'b0) begin miscompares++; $display("FAIL reset_cpu_en got %b want 0", cpu_en); end
        vectors++; if (cycles !== 4'd0) begin miscompares++; $display("FAIL reset_cycles got %0d want 0", cycles); end
        vectors++; if (tick !== 1'b0) begin miscompares++; $display("FAIL reset_tick got %b want 0", tick); end
    endtask

    task automatic test_step();
        mode = 1'b1;
        repeat (8) @(negedge clk);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        vectors++; if (state !== 2'b11) begin miscompares++; $display("FAIL step_state got %b want 11", state); end
        vectors++; if (cpu_en !== 1'b1) begin miscompares++; $display("FAIL step_cpu_en got %b want 1", cpu_en); end
        @(negedge clk);
        vectors++; if (state !== 2'b00) begin miscompares++; $display("FAIL step_after_state got %b want 00", state); end
        vectors++; if (cpu_en !== 1'b0) begin miscompares++; $display("FAIL step_after_cpu_en got %b want 0", cpu_en); end
        vectors++; if (cycles !== 4'd1) begin miscompares++; $display("FAIL step_cycles got %0d want 1", cycles); end
        vectors++; if (tick !== 1'b1) begin miscompares++; $display("FAIL step_tick got %b want 1", tick); end
        // step held two cycles: the second is dropped while in STEP
        step = 1'b1;
        @(negedge clk);
        @(negedge clk);
        step = 1'b0;
        vectors++; if (state !== 2'b00) begin miscompares++; $display("FAIL step_held_state got %b want 00", state); end
        vectors++; if (cycles !== 4'd2) begin miscompares++; $display("FAIL step_held_cycles got %0d want 2", cycles); end
        // run in STEP mode is ignored
        pulse_run();
        @(negedge clk);
        vectors++; if (state !== 2'b00) begin miscompares++; $display("FAIL step_mode_run_state got %b want 00", state); end
    endtask

    task automatic test_auto();
        do_reset();
        mode = 1'b0; divisor = 26'd3;
        pulse_run();
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            vectors++;
            if (cpu_en !== ((i % 4) == 0)) begin
                miscompares++; $display("FAIL auto_cpu_en cycle %0d got %b want %b", i, cpu_en, ((i % 4) == 0));
            end
        end
        vectors++; if (cycles !== 4'd5) begin miscompares++; $display("FAIL auto_cycles got %0d want 5", cycles); end
        vectors++; if (tick !== 1'b1) begin miscompares++; $display("FAIL auto_tick got %b want 1", tick); end
        halt = 1'b1;
        @(negedge clk);
        halt = 1'b0;
        vectors++; if (state !== 2'b00) begin miscompares++; $display("FAIL auto_halt_state got %b want 00", state); end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            vectors++; if (cpu_en !== 1'b0) begin miscompares++; $display("FAIL auto_halt_cpu_en cycle %0d got %b want 0", i, cpu_en); end
        end
        vectors++; if (cycles !== 4'd5) begin miscompares++; $display("FAIL auto_halt_cycles got %0d want 5", cycles); end
    endtask

    task automatic test_mode_exit();
        do_reset();
        mode = 1'b0; divisor = 26'd0;
        pulse_run();
        repeat (2) @(negedge clk);
        mode = 1'b1;
        @(negedge clk);
        vectors++; if (state !== 2'b00) begin miscompares++; $display("FAIL mode_exit_state got %b want 00", state); end
        vectors++; if (cpu_en !== 1'b0) begin miscompares++; $display("FAIL mode_exit_cpu_en got %b want 0", cpu_en); end
        mode = 1'b0;
    endtask

    task automatic test_divisor_lower();
        do_reset();
        mode = 1'b0; divisor = 26'd10;
        pulse_run();
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            vectors++; if (cpu_en !== 1'b0) begin miscompares++; $display("FAIL div_low_wait cycle %0d got %b want 0", i, cpu_en); end
        end
        divisor = 26'd2;
        @(negedge clk);
        vectors++; if (cpu_en !== 1'b1) begin miscompares++; $display("FAIL div_low_issue got %b want 1", cpu_en); end
        @(negedge clk);
        vectors++; if (cpu_en !== 1'b0) begin miscompares++; $display("FAIL div_low_reload got %b want 0", cpu_en); end
    endtask

    task automatic test_priority();
        do_reset();
        mode = 1'b0; divisor = 26'd0;
        pulse_run();
        repeat (3) @(negedge clk);
        halt = 1'b1; step = 1'b1; run = 1'b1;
        @(negedge clk);
        halt = 1'b0; step = 1'b0; run = 1'b0;
        vectors++; if (state !== 2'b00) begin miscompares++; $display("FAIL prio_all_state got %b want 00", state); end
        vectors++; if (cpu_en !== 1'b0) begin miscompares++; $display("FAIL prio_all_cpu_en got %b want 0", cpu_en); end
        step = 1'b1; run = 1'b1;
        @(negedge clk);
        step = 1'b0; run = 1'b0;
        vectors++; if (state !== 2'b11) begin miscompares++; $display("FAIL prio_steprun_state got %b want 11", state); end
        vectors++; if (cpu_en !== 1'b1) begin miscompares++; $display("FAIL prio_steprun_cpu_en got %b want 1", cpu_en); end
        @(negedge clk);
        vectors++; if (state !== 2'b00) begin miscompares++; $display("FAIL prio_after_state got %b want 00", state); end
        @(negedge clk);
        vectors++; if (state !== 2'b00) begin miscompares++; $display("FAIL prio_settle_state got %b want 00", state); end
        vectors++; if (cpu_en !== 1'b0) begin miscompares++; $display("FAIL prio_settle_cpu_en got %b want 0", cpu_en); end
    endtask

    task automatic test_breakpoint();
        do_reset();
        mode = 1'b0; divisor = 26'd0; brk_en = 1'b1; brk_addr = 8'h05;
        pulse_run();
        repeat (6) @(negedge clk);
`ifdef EXEC_CTRL_BRK_EN
        vectors++; if (state !== 2'b10) begin miscompares++; $display("FAIL brk_hit_state got %b want 10", state); end
        vectors++; if (cycles !== 4'd5) begin miscompares++; $display("FAIL brk_hit_cycles got %0d want 5", cycles); end
        vectors++; if (cpu_en !== 1'b0) begin miscompares++; $display("FAIL brk_hit_cpu_en got %b want 0", cpu_en); end
        repeat (2) @(negedge clk);
        vectors++; if (state !== 2'b10) begin miscompares++; $display("FAIL brk_hold_state got %b want 10", state); end
        pulse_run();
        vectors++; if (state !== 2'b01) begin miscompares++; $display("FAIL brk_resume_state got %b want 01", state); end
        @(negedge clk);
        vectors++; if (cpu_en !== 1'b1) begin miscompares++; $display("FAIL brk_skip_cpu_en got %b want 1", cpu_en); end
        repeat (3) @(negedge clk);
        vectors++; if (state !== 2'b01) begin miscompares++; $display("FAIL brk_no_rehit_state got %b want 01", state); end
        vectors++; if (cycles !== 4'd9) begin miscompares++; $display("FAIL brk_no_rehit_cycles got %0d want 9", cycles); end
`else
        vectors++; if (state !== 2'b01) begin miscompares++; $display("FAIL nobrk_state got %b want 01", state); end
        vectors++; if (cycles !== 4'd6) begin miscompares++; $display("FAIL nobrk_cycles got %0d want 6", cycles); end
        repeat (3) @(negedge clk);
        vectors++; if (state !== 2'b01) begin miscompares++; $display("FAIL nobrk_later_state got %b want 01", state); end
        vectors++; if (cycles !== 4'd9) begin miscompares++; $display("FAIL nobrk_later_cycles got %0d want 9", cycles); end
`endif
        brk_en = 1'b0;
    endtask

    task automatic test_wrap();
        do_reset();
        mode = 1'b0; divisor = 26'd0; brk_en = 1'b0;
        pulse_run();
        for (int i = 1; i <= 17; i++) begin
            @(negedge clk);
            if (i == 16) begin
                vectors++; if (cycles !== 4'd0) begin miscompares++; $display("FAIL wrap_16_cycles got %0d want 0", cycles); end
            end
        end
        vectors++; if (cycles !== 4'd1) begin miscompares++; $display("FAIL wrap_17_cycles got %0d want 1", cycles); end
        vectors++; if (tick !== 1'b1) begin miscompares++; $display("FAIL wrap_tick got %b want 1", tick); end
        vectors++; if (state !== 2'b01) begin miscompares++; $display("FAIL wrap_state got %b want 01", state); end
    endtask

    task automatic test_reset_midrun();
        // continues from the running state left by test_wrap
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vectors++; if (state !== 2'b00) begin miscompares++; $display("FAIL midrst_state got %b want 00", state); end
        vectors++; if (cpu_en !== 1'b0) begin miscompares++; $display("FAIL midrst_cpu_en got %b want 0", cpu_en); end
        vectors++; if (cycles !== 4'd0) begin miscompares++; $display("FAIL midrst_cycles got %0d want 0", cycles); end
        vectors++; if (tick !== 1'b0) begin miscompares++; $display("FAIL midrst_tick got %b want 0", tick); end
        repeat (2) @(negedge clk);
        vectors++; if (cpu_en !== 1'b0) begin miscompares++; $display("FAIL midrst_idle_cpu_en got %b want 0", cpu_en); end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b1; mode = 1'b1; divisor = 26'd0; run = 1'b0; halt = 1'b0;
        step = 1'b0; brk_addr = 8'd0; brk_en = 1'b0;
        test_reset();
        test_step();
        test_auto();
        test_mode_exit();
        test_divisor_lower();
        test_priority();
        test_breakpoint();
        test_wrap();
        test_reset_midrun();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
